data_bus_responder: RTL and testbench

DATA_BUS_RESPONDER -- requirements
Module: data_bus_responder

---
 rtl/data_bus_responder.sv | 131 +++++++++++++
 tb/tb_data_bus_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// ============================================================================
// data_bus_responder : word-addressed RAM plus keypad RX and display TX FIFOs
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module data_bus_responder #(
  parameter int RAM_WORDS  = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WD,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  input  logic        key_valid,
  input  logic [7:0]  key_data,
  output logic        disp_valid,
  output logic [31:0] disp_data,
  input  logic        disp_ready
);

  localparam int AW = $clog2(RAM_WORDS);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);
  localparam logic [29:0]   RAM_LIMIT = 30'(RAM_WORDS);
  localparam logic [29:0]   A_STATUS  = 30'h40;
  localparam logic [29:0]   A_RX_DATA = 30'h41;
  localparam logic [29:0]   A_RX_POP  = 30'h42;
  localparam logic [29:0]   A_TX_DATA = 30'h43;
  localparam logic [29:0]   A_CLR_ERR = 30'h44;

  logic [31:0]   mem    [RAM_WORDS];
  logic [7:0]    rx_mem [FIFO_DEPTH];
  logic [31:0]   tx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wr, rx_rd, tx_wr, tx_rd;
  logic [CW-1:0] rx_count, tx_count;
  logic          rx_ovf, tx_ovf;

  logic [29:0]   word_addr;
  logic [AW-1:0] ram_idx;
  logic          is_ram, ram_we, clr_err;
  logic          rx_pop, rx_push, rx_drop;
  logic          tx_wr_req, disp_pop, tx_push, tx_drop;
  logic [31:0]   status, rx_head;
  logic          unused_byte_offset;

  assign word_addr          = ALUResult[31:2];
  assign ram_idx            = ALUResult[AW+1:2];
  assign unused_byte_offset = ^ALUResult[1:0];
  assign is_ram             = word_addr < RAM_LIMIT;
  assign ram_we             = MemWrite && is_ram;
  assign clr_err            = MemWrite && (word_addr == A_CLR_ERR);

  // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
  assign rx_pop    = MemWrite && (word_addr == A_RX_POP) && (rx_count != '0);
  assign rx_push   = key_valid && ((rx_count != DEPTH) || rx_pop);
  assign rx_drop   = key_valid && !rx_push;
  assign tx_wr_req = MemWrite && (word_addr == A_TX_DATA);
  assign disp_pop  = disp_valid && disp_ready;
  assign tx_push   = tx_wr_req && ((tx_count != DEPTH) || disp_pop);
  assign tx_drop   = tx_wr_req && !tx_push;

  assign disp_valid = (tx_count != '0);
  assign disp_data  = disp_valid ? tx_mem[tx_rd] : '0;
  assign rx_head    = (rx_count != '0) ? {24'b0, rx_mem[rx_rd]} : '0;
  assign status     = {22'b0, tx_ovf, rx_ovf, 3'(tx_count), 3'(rx_count),
                       (tx_count == DEPTH), (rx_count != '0)};

  always_comb begin
    ReadData = '0;
    if (is_ram) begin
      ReadData = mem[ram_idx];
    end else begin
      case (word_addr)
        A_STATUS:  ReadData = status;
        A_RX_DATA: ReadData = rx_head;
        default:   ReadData = '0;
      endcase
    end
  end

  // Storage arrays keep their contents across reset; only control state clears.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
    end else begin
      if (ram_we)  mem[ram_idx]  <= WD;
      if (rx_push) rx_mem[rx_wr] <= key_data;
      if (tx_push) tx_mem[tx_wr] <= WD;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rx_wr    <= '0;
      rx_rd    <= '0;
      tx_wr    <= '0;
      tx_rd    <= '0;
      rx_count <= '0;
      tx_count <= '0;
      rx_ovf   <= 1'b0;
      tx_ovf   <= 1'b0;
    end else begin
      if (rx_push) rx_wr <= rx_wr + PW'(1);
      if (rx_pop)  rx_rd <= rx_rd + PW'(1);
      if (tx_push) tx_wr <= tx_wr + PW'(1);
      if (disp_pop) tx_rd <= tx_rd + PW'(1);

      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + CW'(1);
        2'b01:   rx_count <= rx_count - CW'(1);
        default: rx_count <= rx_count;
      endcase
      case ({tx_push, disp_pop})
        2'b10:   tx_count <= tx_count + CW'(1);
        2'b01:   tx_count <= tx_count - CW'(1);
        default: tx_count <= tx_count;
      endcase

      if (rx_drop)      rx_ovf <= 1'b1;
      else if (clr_err) rx_ovf <= 1'b0;
      if (tx_drop)      tx_ovf <= 1'b1;
      else if (clr_err) tx_ovf <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_bus_responder.sv
// ============================================================================
// tb_data_bus_responder : directed + randomized check against a queue model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_data_bus_responder;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] ALUResult, WD, ReadData, disp_data;
  logic        MemWrite, key_valid, disp_valid, disp_ready;
  logic [7:0]  key_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ram_m [64];
  bit          ram_ok [64];
  logic [7:0]  rxq [$];
  logic [31:0] txq [$];
  bit          rx_ovf_m, tx_ovf_m;

  data_bus_responder #(.RAM_WORDS(64), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .ALUResult(ALUResult), .WD(WD), .MemWrite(MemWrite),
    .ReadData(ReadData), .key_valid(key_valid), .key_data(key_data),
    .disp_valid(disp_valid), .disp_data(disp_data), .disp_ready(disp_ready)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] status_m();
    int v;
    v = (tx_ovf_m ? 512 : 0) + (rx_ovf_m ? 256 : 0) + txq.size() * 32 + rxq.size() * 4
      + (txq.size() == 4 ? 2 : 0) + (rxq.size() > 0 ? 1 : 0);
    return 32'(v);
  endfunction

  function automatic logic [31:0] read_m(input logic [31:0] addr, output bit known);
    logic [31:0] word;
    word  = addr & 32'hFFFF_FFFC;
    known = 1'b1;
    if (addr < 32'h100) begin
      known = ram_ok[addr[7:2]];
      return ram_m[addr[7:2]];
    end
    if (word == 32'h100) return status_m();
    if (word == 32'h104) return (rxq.size() > 0) ? {24'b0, rxq[0]} : 32'h0;
    return 32'h0;
  endfunction

  function automatic logic [31:0] head_tx();
    return (txq.size() > 0) ? txq[0] : 32'h0;
  endfunction

  // Apply one bus cycle: check combinational outputs, clock, then advance the model.
  task automatic step(input logic [31:0] addr, input logic [31:0] wd, input bit we,
                      input bit kv, input logic [7:0] kd, input bit dr);
    logic [31:0] exp, word;
    bit known;
    ALUResult = addr; WD = wd; MemWrite = we; key_valid = kv; key_data = kd; disp_ready = dr;
    #1;
    exp = read_m(addr, known);
    if (known) check("ReadData", ReadData, exp);
    check("disp_valid", {31'b0, disp_valid}, (txq.size() > 0) ? 32'h1 : 32'h0);
    check("disp_data", disp_data, head_tx());
    @(posedge CLK);
    #1;
    word = addr & 32'hFFFF_FFFC;
    if (we && word == 32'h110) begin rx_ovf_m = 0; tx_ovf_m = 0; end
    if (dr && txq.size() > 0) void'(txq.pop_front());
    if (we && word == 32'h108 && rxq.size() > 0) void'(rxq.pop_front());
    if (kv) begin
      if (rxq.size() < 4) rxq.push_back(kd);
      else rx_ovf_m = 1;
    end
    if (we && word == 32'h10C) begin
      if (txq.size() < 4) txq.push_back(wd);
      else tx_ovf_m = 1;
    end
    if (we && addr < 32'h100) begin
      ram_m[addr[7:2]]  = wd;
      ram_ok[addr[7:2]] = 1'b1;
    end
    MemWrite = 0; key_valid = 0; disp_ready = 0; ALUResult = 32'h300;
  endtask

  task automatic peek(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    ALUResult = addr;
    #1;
    check(tag, ReadData, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1; ALUResult = 32'h300; WD = 0; MemWrite = 0;
    key_valid = 0; key_data = 0; disp_ready = 0;
    #12;
    check("rst_disp_valid", {31'b0, disp_valid}, 32'h0);
    check("rst_disp_data", disp_data, 32'h0);
    peek("rst_status", 32'h100, 32'h0);
    @(negedge CLK); RST = 0;
    @(posedge CLK); #1;

    // RAM store/load, byte offset ignored, unmapped reads zero
    step(32'h0F0, 32'hDEADBEEF, 1, 0, 0, 0);
    peek("ram_f0", 32'h0F0, 32'hDEADBEEF);
    peek("ram_f3", 32'h0F3, 32'hDEADBEEF);
    peek("unmapped", 32'h200, 32'h0);

    // Key FIFO overflow, pop and clear-error
    for (int k = 8'h31; k <= 8'h35; k++) step(32'h300, 0, 0, 1, 8'(k), 0);
    peek("rx_status_full", 32'h100, 32'h111);
    peek("rx_head0", 32'h104, 32'h31);
    step(32'h108, 0, 1, 0, 0, 0);
    peek("rx_head1", 32'h104, 32'h32);
    step(32'h110, 0, 1, 0, 0, 0);
    peek("rx_clr", 32'h100, 32'h00D);
    for (int i = 0; i < 3; i++) step(32'h108, 0, 1, 0, 0, 0);

    // Display FIFO back-pressure then drain
    for (int i = 1; i <= 5; i++) step(32'h10C, 32'(i), 1, 0, 0, 0);
    peek("tx_status_full", 32'h100, 32'h282);
    check("tx_hold", disp_data, 32'h1);
    step(32'h300, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      check("tx_emit", disp_data, 32'(i + 1));
      step(32'h300, 0, 0, 0, 0, 1);
    end
    check("tx_drained", {31'b0, disp_valid}, 32'h0);
    step(32'h110, 0, 1, 0, 0, 0);

    // Full-boundary simultaneity on both FIFOs
    for (int i = 0; i < 4; i++) step(32'h10C, 32'h10 + 32'(i), 1, 0, 0, 0);
    step(32'h10C, 32'hA5, 1, 0, 0, 1);
    peek("tx_simul", 32'h100, 32'h082);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) check("tx_a5_last", disp_data, 32'hA5);
      step(32'h300, 0, 0, 0, 0, 1);
    end
    for (int k = 8'h41; k <= 8'h44; k++) step(32'h300, 0, 0, 1, 8'(k), 0);
    step(32'h108, 0, 1, 1, 8'h45, 0);
    peek("rx_simul", 32'h100, 32'h011);
    for (int i = 0; i < 4; i++) step(32'h108, 0, 1, 0, 0, 0);

    // Pointer wrap through both FIFOs
    for (int i = 0; i < 10; i++) begin
      step(32'h10C, 32'h100 + 32'(i), 1, 1, 8'(i), 0);
      peek("wrap_rx", 32'h104, 32'(i));
      check("wrap_tx", disp_data, 32'h100 + 32'(i));
      step(32'h108, 0, 1, 0, 0, 1);
    end
    peek("wrap_empty", 32'h100, 32'h0);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      case ($urandom_range(0, 8))
        0, 1, 2: a = 32'($urandom_range(0, 63)) * 4;
        3:       a = 32'h100;
        4:       a = 32'h104;
        5:       a = 32'h108;
        6:       a = 32'h10C;
        7:       a = 32'h110;
        default: a = 32'h114 + 32'($urandom_range(0, 255)) * 4;
      endcase
      a = a | 32'($urandom_range(0, 3));
      step(a, $urandom, 1'($urandom), ($urandom % 3) == 0, 8'($urandom), ($urandom % 4) == 0);
    end

    // Reset mid-operation
    for (int i = 0; i < 6; i++) step(32'h108, 0, 1, 0, 0, 1);
    step(32'h110, 0, 1, 0, 0, 0);
    step(32'h0F0, 32'h12345678, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(32'h10C, 32'h70 + 32'(i), 1, 0, 0, 0);
    check("pre_rst_valid", {31'b0, disp_valid}, 32'h1);
    #2;
    RST = 1; ALUResult = 32'h0F0; WD = 32'h0BAD0BAD; MemWrite = 1;
    #1;
    check("rst_mid_valid", {31'b0, disp_valid}, 32'h0);
    check("rst_mid_data", disp_data, 32'h0);
    peek("rst_mid_status", 32'h100, 32'h0);
    ALUResult = 32'h0F0;
    @(posedge CLK); #1;
    check("rst_ram_kept", ReadData, 32'h12345678);
    rxq.delete(); txq.delete(); rx_ovf_m = 0; tx_ovf_m = 0;
    @(negedge CLK); RST = 0; MemWrite = 0;
    @(posedge CLK); #1;
    step(32'h10C, 32'h99, 1, 1, 8'h5A, 0);
    step(32'h104, 0, 0, 0, 0, 1);
    step(32'h100, 0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
